// File: rtl/exec_stage_pkg.sv
// Shared configuration for the execute stage: datapath widths (PECfg) and
// the control/result beat typedefs (PECtlCfg).
package PECfg;
    localparam int DWD     = 8;   // signed input/weight operand width
    localparam int PSUMDWD = 16;  // signed partial-sum width, >= 2*DWD
    localparam int PEROW   = 3;   // number of lanes
endpackage : PECfg

package PECtlCfg;
    // Per-beat control carried alongside the lane operands.
    typedef struct packed {
        logic bypass;  // 1: pass Psum through untouched
        logic last;    // end-of-group marker, forwarded to o_last
    } ESctl;

    // One lane operand record as delivered by the fetch stage (MSB first).
    typedef struct packed {
        logic signed [PECfg::DWD-1:0]     Input_FS;
        logic signed [PECfg::DWD-1:0]     Weight_FS;
        logic signed [PECfg::PSUMDWD-1:0] Psum_FS;
    } FSout;

    // One lane result.
    typedef logic signed [PECfg::PSUMDWD-1:0] ESout;
endpackage : PECtlCfg

// File: rtl/exec_stage_sat.sv
// Signed partial-sum adder with clamp to the representable PSUMDWD range.
// Purely combinational; one instance per lane.
module psum_sat_add #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] psum_i,
    input  logic signed [W-1:0] prod_i,
    output logic signed [W-1:0] sum_o
);

    logic [W:0] wide_s;

    // One guard bit exposes overflow; clamp toward the sign of the true result.
    always_comb begin
        wide_s = {psum_i[W-1], psum_i} + {prod_i[W-1], prod_i};
        if (wide_s[W] != wide_s[W-1]) begin
            if (wide_s[W]) begin
                sum_o = {1'b1, {(W-1){1'b0}}};
            end else begin
                sum_o = {1'b0, {(W-1){1'b1}}};
            end
        end else begin
            sum_o = wide_s[W-1:0];
        end
    end

endmodule : psum_sat_add

// File: rtl/exec_stage.sv
// Two-register execute stage: M holds per-lane products plus Psum, A holds
// the saturated (or bypassed) results. Valid/ready handshake on both sides,
// full throughput with no bubble when both registers advance together.
module exec_stage
    import PECtlCfg::*;
#(
    parameter int DWD     = PECfg::DWD,
    parameter int PSUMDWD = PECfg::PSUMDWD,
    parameter int PEROW   = PECfg::PEROW
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    FS_rdy,
    output logic                                    FS_ack,
    input  logic [PEROW-1:0][2*DWD+PSUMDWD-1:0]     i_data,
    input  ESctl                                    i_ctl,
    output logic                                    ES_rdy,
    input  logic                                    ES_ack,
    output logic [PEROW-1:0][PSUMDWD-1:0]           o_data,
    output logic                                    o_last
);

    // M register (products, Psum, control)
    logic                             m_valid_q;
    logic                             m_valid_d;
    logic [PEROW-1:0][PSUMDWD-1:0]    m_prod_q;
    logic [PEROW-1:0][PSUMDWD-1:0]    m_prod_d;
    logic [PEROW-1:0][PSUMDWD-1:0]    m_psum_q;
    logic [PEROW-1:0][PSUMDWD-1:0]    m_psum_d;
    logic                             m_bypass_q;
    logic                             m_last_q;

    // A register (results, last)
    logic                             a_valid_q;
    logic                             a_valid_d;
    logic [PEROW-1:0][PSUMDWD-1:0]    a_data_q;
    logic [PEROW-1:0][PSUMDWD-1:0]    a_data_d;
    logic                             a_last_q;

    // Handshake terms
    logic                             m_adv_s;
    logic                             a_drain_s;
    logic                             fs_ack_s;
    logic                             fs_xfer_s;

    // Advance/drain decisions; FS_ack depends only on pipeline state and ES_ack.
    always_comb begin
        m_adv_s   = m_valid_q && (!a_valid_q || ES_ack);
        a_drain_s = a_valid_q && ES_ack;
        fs_ack_s  = !m_valid_q || m_adv_s;
        fs_xfer_s = FS_rdy && fs_ack_s;
    end

    // Next-state valid bits: a load wins over an emptying move in the same cycle.
    always_comb begin
        if (fs_xfer_s) begin
            m_valid_d = 1'b1;
        end else if (m_adv_s) begin
            m_valid_d = 1'b0;
        end else begin
            m_valid_d = m_valid_q;
        end
        if (m_adv_s) begin
            a_valid_d = 1'b1;
        end else if (a_drain_s) begin
            a_valid_d = 1'b0;
        end else begin
            a_valid_d = a_valid_q;
        end
    end

    // Per-lane datapath: multiply into M, add/clamp or bypass into A.
    for (genvar l = 0; l < PEROW; l++) begin : g_lane
        logic signed [DWD-1:0]     in_s;
        logic signed [DWD-1:0]     wt_s;
        logic signed [2*DWD-1:0]   prod_s;
        logic signed [PSUMDWD-1:0] sum_s;

        assign in_s        = i_data[l][2*DWD+PSUMDWD-1 -: DWD];
        assign wt_s        = i_data[l][DWD+PSUMDWD-1 -: DWD];
        assign prod_s      = (2*DWD)'(in_s) * (2*DWD)'(wt_s);
        assign m_prod_d[l] = PSUMDWD'(prod_s);
        assign m_psum_d[l] = i_data[l][PSUMDWD-1:0];

        psum_sat_add #(
            .W (PSUMDWD)
        ) u_psum_sat_add (
            .psum_i (m_psum_q[l]),
            .prod_i (m_prod_q[l]),
            .sum_o  (sum_s)
        );

        assign a_data_d[l] = m_bypass_q ? m_psum_q[l] : sum_s;
    end

    // M register: payload loads only on an accepted fetch beat.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            m_valid_q  <= 1'b0;
            m_prod_q   <= '0;
            m_psum_q   <= '0;
            m_bypass_q <= 1'b0;
            m_last_q   <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            if (fs_xfer_s) begin
                m_prod_q   <= m_prod_d;
                m_psum_q   <= m_psum_d;
                m_bypass_q <= i_ctl.bypass;
                m_last_q   <= i_ctl.last;
            end
        end
    end

    // A register: loads from M only when M advances, otherwise holds for the consumer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            a_valid_q <= 1'b0;
            a_data_q  <= '0;
            a_last_q  <= 1'b0;
        end else begin
            a_valid_q <= a_valid_d;
            if (m_adv_s) begin
                a_data_q <= a_data_d;
                a_last_q <= m_last_q;
            end
        end
    end

    assign FS_ack = fs_ack_s;
    assign ES_rdy = a_valid_q;
    assign o_data = a_data_q;
    assign o_last = a_last_q;

endmodule : exec_stage

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: vector table with hand-computed
// results, scoreboard queue of expected beats, plus sequences for
// back-pressure, streaming and reset mid-operation.
module tb_exec_stage;

    localparam int DWD = 8;
    localparam int PSUMDWD = 16;
    localparam int PEROW = 3;
    localparam int NV = 6;

    typedef struct {
        int in_v  [PEROW];
        int w_v   [PEROW];
        int ps_v  [PEROW];
        int exp_v [PEROW];
        bit bp;
        bit last;
    } vec_t;

    typedef struct packed {
        logic [PEROW-1:0][PSUMDWD-1:0] d;
        logic                          last;
    } exp_t;

    logic                                 i_clk = 1'b0;
    logic                                 i_rst;
    logic                                 FS_rdy;
    logic                                 FS_ack;
    logic [PEROW-1:0][2*DWD+PSUMDWD-1:0]  i_data;
    PECtlCfg::ESctl                       i_ctl;
    logic                                 ES_rdy;
    logic                                 ES_ack;
    logic [PEROW-1:0][PSUMDWD-1:0]        o_data;
    logic                                 o_last;

    exec_stage #(.DWD(DWD), .PSUMDWD(PSUMDWD), .PEROW(PEROW)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .FS_rdy (FS_rdy),
        .FS_ack (FS_ack),
        .i_data (i_data),
        .i_ctl  (i_ctl),
        .ES_rdy (ES_rdy),
        .ES_ack (ES_ack),
        .o_data (o_data),
        .o_last (o_last)
    );

    always #5 i_clk = ~i_clk;

    vec_t  tbl [NV];
    exp_t  exp_q [$];
    int    out_cyc [$];
    exp_t  cur_exp;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    acc_count = 0;
    int    first_xfer = -1;
    int    first_low_acc = -1;
    bit    accepted = 1'b0;
    bit    stall_prev = 1'b0;
    logic [PEROW-1:0][PSUMDWD-1:0] held_data;
    logic  held_last;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic set_vec(input int k, input int a0, input int b0, input int c0, input int e0,
                           input int a1, input int b1, input int c1, input int e1,
                           input int a2, input int b2, input int c2, input int e2,
                           input bit bp, input bit last);
        tbl[k].in_v[0] = a0; tbl[k].w_v[0] = b0; tbl[k].ps_v[0] = c0; tbl[k].exp_v[0] = e0;
        tbl[k].in_v[1] = a1; tbl[k].w_v[1] = b1; tbl[k].ps_v[1] = c1; tbl[k].exp_v[1] = e1;
        tbl[k].in_v[2] = a2; tbl[k].w_v[2] = b2; tbl[k].ps_v[2] = c2; tbl[k].exp_v[2] = e2;
        tbl[k].bp = bp;
        tbl[k].last = last;
    endtask

    task automatic set_beat(input int k);
        for (int l = 0; l < PEROW; l++) begin
            i_data[l]    = {8'(tbl[k].in_v[l]), 8'(tbl[k].w_v[l]), 16'(tbl[k].ps_v[l])};
            cur_exp.d[l] = 16'(tbl[k].exp_v[l]);
        end
        i_ctl.bypass = tbl[k].bp;
        i_ctl.last   = tbl[k].last;
        cur_exp.last = tbl[k].last;
    endtask

    // One clock: observe at the falling edge, then return #1 after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge i_clk);
        accepted = 1'b0;
        if (stall_prev) begin
            checks++;
            if (!(ES_rdy && o_data == held_data && o_last == held_last)) begin
                failures++;
                $display("FAIL hold: rdy=%0b data=%h last=%0b expected data=%h last=%0b",
                         ES_rdy, o_data, o_last, held_data, held_last);
            end
        end
        stall_prev = ES_rdy && !ES_ack;
        held_data  = o_data;
        held_last  = o_last;
        if (!FS_ack && first_low_acc < 0) first_low_acc = acc_count;
        if (FS_rdy && FS_ack) begin
            accepted = 1'b1;
            acc_count++;
            exp_q.push_back(cur_exp);
            if (first_xfer < 0) first_xfer = cyc;
        end
        if (ES_rdy && ES_ack) begin
            checks++;
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL out_unexpected: got data=%h last=%0b expected no beat", o_data, o_last);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e.d || o_last !== e.last) begin
                    failures++;
                    $display("FAIL out_beat: got data=%h last=%0b expected data=%h last=%0b",
                             o_data, o_last, e.d, e.last);
                end
            end
        end
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    // Offer n beats from the table back-to-back; ES_ack held low for ack_hold cycles.
    task automatic send(input int first, input int n, input int ack_hold, input int budget);
        int idx = 0;
        int c = 0;
        while (idx < n && c < budget) begin
            set_beat((first + idx) % NV);
            FS_rdy = 1'b1;
            ES_ack = (c >= ack_hold);
            tick();
            if (accepted) idx++;
            c++;
        end
        FS_rdy = 1'b0;
        chk("send_accepted", idx, n);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        ES_ack = 1'b1;
        while (exp_q.size() > 0 && c < budget) begin
            tick();
            c++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic clear_track();
        out_cyc.delete();
        first_xfer = -1;
        first_low_acc = -1;
        acc_count = 0;
    endtask

    initial begin
        // in, w, psum, expected per lane; bypass; last
        set_vec(0,    3,   4,     10,     22,     0,   0,      0,      0,   -2,    3,      5,     -1, 1'b0, 1'b0);
        set_vec(1,  127, 127,  20000,  32767,  -128, 127, -20000, -32768, -128, -128,      0,  16384, 1'b0, 1'b1);
        set_vec(2,    5,   5,     -7,     -7,   100, 100,   1234,   1234,   -1,   -1,  32767,  32767, 1'b1, 1'b1);
        set_vec(3,  127, 127,  16638,  32767,  -128, 127, -16512, -32768,  127, -128,      0, -16256, 1'b0, 1'b0);
        set_vec(4,  127, 127,  16639,  32767,  -128, 127, -16513, -32768,   10,  -10,    -50,   -150, 1'b0, 1'b1);
        set_vec(5,    0,   0, -32768, -32768,     1,   1,  32767,  32767,   -1,    1, -32768, -32768, 1'b0, 1'b0);

        i_rst  = 1'b0;
        FS_rdy = 1'b0;
        ES_ack = 1'b0;
        i_data = '0;
        i_ctl  = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_es_rdy", ES_rdy, 0);
        chk("rst_fs_ack", FS_ack, 1);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_last", o_last, 0);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;

        // Table vectors, one beat at a time with a 2-cycle latency check each.
        for (int k = 0; k < NV; k++) begin
            clear_track();
            send(k, 1, 0, 20);
            drain(10);
            chk("lat_table", (out_cyc.size() > 0) ? out_cyc[0] - first_xfer : -1, 2);
        end

        // Back-pressure: 5 beats, consumer stalled for the first 4 cycles.
        clear_track();
        send(0, 5, 4, 40);
        drain(20);
        chk("bp_acc_before_stall", first_low_acc, 2);
        chk("bp_outputs", out_cyc.size(), 5);

        // Streaming: 10 beats with ES_ack held high.
        clear_track();
        send(1, 10, 0, 40);
        drain(10);
        chk("stream_outputs", out_cyc.size(), 10);
        chk("stream_first", (out_cyc.size() > 0) ? out_cyc[0] - first_xfer : -1, 2);
        for (int i = 1; i < out_cyc.size(); i++) begin
            chk("stream_consecutive", out_cyc[i] - out_cyc[i-1], 1);
        end

        // Reset mid-operation with both registers full.
        clear_track();
        send(3, 2, 100, 10);
        chk("full_es_rdy", ES_rdy, 1);
        chk("full_fs_ack", FS_ack, 0);
        @(negedge i_clk);
        #2;
        i_rst = 1'b0;
        #1;
        chk("mid_rst_es_rdy", ES_rdy, 0);
        chk("mid_rst_o_data", o_data, 0);
        chk("mid_rst_o_last", o_last, 0);
        chk("mid_rst_fs_ack", FS_ack, 1);
        exp_q.delete();
        stall_prev = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        clear_track();
        send(0, 1, 0, 10);
        drain(10);
        chk("post_rst_outputs", out_cyc.size(), 1);
        chk("post_rst_lat", (out_cyc.size() > 0) ? out_cyc[0] - first_xfer : -1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_exec_stage
